tile_buffer: RTL and testbench
==============================

# tile_buffer

Double-buffered tile colour store that sits directly downstream of the VGA controller. It serves the controller's block read requests (`re`, `raddr`) with a per-tile colour code for the pixel output stage. Game logic writes the next board into a back bank. A requested bank swap is taken only at a frame boundary, so the display never tears. The block also provides a hardware clear of the back bank and a power-up clear of both banks.

## Interface
Parameters:
- `CW`, default 3: colour code width per tile.
- `VBLOCKS`, default 24: number of valid vertical blocks. Reads with vblock ≥ `VBLOCKS` return 0.
- `BGCOLOR`, default 0: value written by a clear.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `re`, in, 1: read enable from the VGA controller.
- `raddr`, in, 10: read address {hblock[4:0], vblock[4:0]}.
- `rdata`, out, `CW`: registered colour of the addressed tile.
- `frame_start`, in, 1: one-cycle pulse at the start of the vertical porch; the swap point.
- `we`, in, 1: back-bank write enable.
- `waddr`, in, 10: write address, same packing as `raddr`.
- `wdata`, in, `CW`: tile colour to write.
- `clear_req`, in, 1: one-cycle pulse requesting a fill of the back bank with `BGCOLOR`.
- `swap_req`, in, 1: one-cycle pulse requesting a front/back exchange.
- `swap_ack`, out, 1: one-cycle pulse issued when the exchange takes effect.
- `busy`, out, 1: high during INIT or CLEAR; writes are ignored while high.
- `front_sel`, out, 1: index of the bank currently displayed.

## Operation
- Storage: two banks of 1024 × `CW`, addressed directly by the 10-bit address. Bank contents are not reset.
- Read path:
  - When `re` = 1, `rdata` ← bank[`front_sel`][`raddr`] on the next edge, or 0 if `raddr[4:0]` ≥ `VBLOCKS`.
  - When `re` = 0, `rdata` holds its value.
- Write path: when `we` = 1 and `busy` = 0, bank[~`front_sel`][`waddr`] ← `wdata`. Writes to the front bank are impossible.
- FSM states are INIT, IDLE, CLEAR and SWAP_WAIT. A 10-bit sweep counter `clr_addr` serves INIT and CLEAR.
  - INIT, entered on reset: writes `BGCOLOR` to both banks at `clr_addr`, one address per cycle. At 1023 it goes to IDLE and `clr_addr` wraps to 0.
  - IDLE:
    - `clear_req` → CLEAR.
    - Otherwise `swap_req` → SWAP_WAIT.
    - If both arrive in the same cycle, `clear_req` wins and the swap is latched in `swap_pend`.
  - CLEAR: writes `BGCOLOR` to the back bank at `clr_addr`. At 1023 it goes to SWAP_WAIT if `swap_pend` is set, else to IDLE.
  - SWAP_WAIT: on `frame_start`, `front_sel` toggles, `swap_ack` pulses, `swap_pend` clears, and the FSM returns to IDLE.
- Duplicate requests:
  - A `swap_req` received while a swap is already pending is absorbed; only one ack is issued.
  - A `clear_req` received during INIT or CLEAR is ignored.
  - A `clear_req` received in SWAP_WAIT is ignored; game logic must wait for `swap_ack`.
- `busy` = (state is INIT or CLEAR).

## Timing
- Reset values:
  - `rdata` = 0, `swap_ack` = 0, `front_sel` = 0.
  - `busy` = 1, because the FSM is in INIT with `clr_addr` = 0.
  - `swap_pend` = 0.
- Reset asserted mid-operation aborts any clear or swap immediately. INIT restarts after release.
- INIT lasts 1024 cycles. `busy` falls on the edge after the write to address 1023.
- Read latency is 1 cycle from `re`.
- A write followed by a read of the same address is visible only after a swap; writes never target the front bank.
- CLEAR: `busy` rises on the edge after `clear_req` and stays high for exactly 1024 cycles.
- Swap timing:
  - `front_sel` and `swap_ack` change on the edge that samples `frame_start` in SWAP_WAIT.
  - A read issued in that same cycle uses the old front bank.
  - Latency from `swap_req` to swap ranges from 1 cycle to one full frame, plus 1024 cycles if a clear was pending.
- A write with `we` in the cycle of the swap edge lands in the old back bank, which becomes the displayed bank.
- A `frame_start` that arrives in IDLE or CLEAR has no effect.

## Test plan
1. Power-up: release `reset` and issue `re` on every address.
   - `busy` stays high for 1024 cycles.
   - Every read returns 0.
   - `front_sel` = 0.
2. Write and swap:
   - Write 3'd5 to address {5'd4, 5'd2}, pulse `swap_req`, then pulse `frame_start`.
   - `swap_ack` goes high for 1 cycle and `front_sel` = 1.
   - `re` at {4,2} → `rdata` = 5 one cycle later.
3. No tearing: write 3'd7 to {0,0} with no swap, then read {0,0}. `rdata` stays at the old value; the new value appears only after the swap.
4. Simultaneous clear and swap:
   - Pulse `clear_req` and `swap_req` in the same cycle, and pulse `frame_start` during the clear.
   - No ack is issued during the clear.
   - The ack arrives on the first `frame_start` after `busy` falls.
   - The new front bank reads all `BGCOLOR`.
5. Out-of-range reads and writes while busy:
   - A read with vblock = 24..31 returns 0.
   - A `we` issued during CLEAR leaves the target at `BGCOLOR` after the swap.
6. Mid-clear reset:
   - Assert `reset` at `clr_addr` = 500.
   - `busy` stays high and `front_sel` = 0.
   - INIT takes a full 1024 cycles from release.

Source files
------------

// File: rtl/tile_buffer.sv
// Double-buffered tile colour store feeding the VGA pixel stage.
// Bank swaps happen only on frame_start; INIT/CLEAR sweep banks with BGCOLOR.
module tile_buffer #(
  parameter int            CW      = 3,
  parameter int            VBLOCKS = 24,
  parameter logic [CW-1:0] BGCOLOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [9:0]    raddr,
  output logic [CW-1:0] rdata,
  input  logic          frame_start,
  input  logic          we,
  input  logic [9:0]    waddr,
  input  logic [CW-1:0] wdata,
  input  logic          clear_req,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          busy,
  output logic          front_sel
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_e;

  localparam logic [5:0] VB = 6'(VBLOCKS);

  state_e        state_q;
  logic [9:0]    clr_addr_q;
  logic [9:0]    clr_addr_d;
  logic          swap_pend_q;
  logic          front_q;
  logic          ack_q;
  logic [CW-1:0] rdata_q;

  logic [CW-1:0] bank0 [1024];
  logic [CW-1:0] bank1 [1024];

  logic          wen0;
  logic          wen1;
  logic [9:0]    wa;
  logic [CW-1:0] wd;
  logic [CW-1:0] rd_raw;
  logic          rd_oor;
  logic          clr_last;

  assign clr_addr_d = clr_addr_q + 10'd1;
  assign clr_last   = &clr_addr_q;
  assign rd_raw     = front_q ? bank1[raddr] : bank0[raddr];
  assign rd_oor     = {1'b0, raddr[4:0]} >= VB;

  // Back bank is always ~front_q; the front bank is never a write target.
  always_comb begin
    wen0 = 1'b0;
    wen1 = 1'b0;
    wa   = waddr;
    wd   = wdata;
    case (state_q)
      INIT: begin
        wen0 = 1'b1;
        wen1 = 1'b1;
        wa   = clr_addr_q;
        wd   = BGCOLOR;
      end
      CLEAR: begin
        wen0 = front_q;
        wen1 = ~front_q;
        wa   = clr_addr_q;
        wd   = BGCOLOR;
      end
      default: begin
        wen0 = we & front_q;
        wen1 = we & ~front_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wen0) bank0[wa] <= wd;
    if (wen1) bank1[wa] <= wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      clr_addr_q  <= '0;
      swap_pend_q <= 1'b0;
      front_q     <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      if (re) rdata_q <= rd_oor ? '0 : rd_raw;
      unique case (state_q)
        INIT: begin
          clr_addr_q <= clr_addr_d;
          if (clr_last) state_q <= IDLE;
        end
        IDLE: begin
          if (clear_req) begin
            state_q     <= CLEAR;
            swap_pend_q <= swap_req;
          end else if (swap_req) begin
            state_q     <= SWAP_WAIT;
            swap_pend_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_d;
          if (swap_req) swap_pend_q <= 1'b1;
          if (clr_last)
            state_q <= (swap_pend_q | swap_req) ? SWAP_WAIT : IDLE;
        end
        SWAP_WAIT: begin
          if (frame_start) begin
            front_q     <= ~front_q;
            ack_q       <= 1'b1;
            swap_pend_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign swap_ack  = ack_q;
  assign front_sel = front_q;
  assign busy      = (state_q == INIT) || (state_q == CLEAR);

endmodule

// File: tb/tb_tile_buffer.sv
// Directed bench for tile_buffer; read results are checked
// against a queue of expected colours pushed when each read is issued.
module tb_tile_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       re = 1'b0;
  logic [9:0] raddr = '0;
  logic [2:0] rdata;
  logic       frame_start = 1'b0;
  logic       we = 1'b0;
  logic [9:0] waddr = '0;
  logic [2:0] wdata = '0;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack;
  logic       busy;
  logic       front_sel;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  tile_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .frame_start(frame_start),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .clear_req  (clear_req),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .busy       (busy),
    .front_sel  (front_sel)
  );

  function automatic logic [9:0] adr(int h, int v);
    logic [4:0] hh;
    logic [4:0] vv;
    hh = 5'(h);
    vv = 5'(v);
    return {hh, vv};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; compares the read issued this cycle, then drops pulses.
  task automatic step();
    logic       did_rd;
    logic [2:0] e;
    did_rd = re;
    @(posedge clk);
    #1;
    if (did_rd) begin
      e = exp_q.pop_front();
      chk($sformatf("rdata@%0h", raddr), {29'd0, rdata}, {29'd0, e});
    end
    re          = 1'b0;
    we          = 1'b0;
    frame_start = 1'b0;
    clear_req   = 1'b0;
    swap_req    = 1'b0;
  endtask

  task automatic do_rd(logic [9:0] a, logic [2:0] e);
    re    = 1'b1;
    raddr = a;
    exp_q.push_back(e);
    step();
  endtask

  task automatic do_wr(logic [9:0] a, logic [2:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      n++;
      if (!busy) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    logic ack_seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", {29'd0, rdata}, 0);
    chk("rst_ack", {31'd0, swap_ack}, 0);
    chk("rst_front", {31'd0, front_sel}, 0);
    chk("rst_busy", {31'd0, busy}, 1);

    reset = 1'b0;
    count_busy(n);
    chk("init_len", n, 1024);
    for (int a = 0; a < 1024; a++) do_rd(10'(a), 3'd0);
    chk("init_front", {31'd0, front_sel}, 0);

    do_wr(adr(4, 2), 3'd5);
    swap_req = 1'b1;
    step();
    chk("sw1_front_pre", {31'd0, front_sel}, 0);
    frame_start = 1'b1;
    re = 1'b1;
    raddr = adr(4, 2);
    exp_q.push_back(3'd0);
    step();
    chk("sw1_ack", {31'd0, swap_ack}, 1);
    chk("sw1_front", {31'd0, front_sel}, 1);
    step();
    chk("sw1_ack_drop", {31'd0, swap_ack}, 0);
    do_rd(adr(4, 2), 3'd5);

    do_wr(adr(0, 0), 3'd7);
    do_rd(adr(0, 0), 3'd0);
    swap_req = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    chk("sw2_front", {31'd0, front_sel}, 0);
    do_rd(adr(0, 0), 3'd7);
    do_rd(adr(4, 2), 3'd0);

    clear_req = 1'b1;
    swap_req  = 1'b1;
    step();
    chk("clr_busy_rise", {31'd0, busy}, 1);
    n = 1;
    ack_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 100) frame_start = 1'b1;
      if (i == 200) begin
        we    = 1'b1;
        waddr = adr(7, 3);
        wdata = 3'd6;
      end
      if (i == 300) swap_req = 1'b1;
      step();
      if (swap_ack) ack_seen = 1'b1;
      if (!busy) break;
      n++;
    end
    chk("clr_len", n, 1024);
    chk("clr_no_ack", {31'd0, ack_seen}, 0);
    chk("clr_front", {31'd0, front_sel}, 0);
    repeat (3) step();
    chk("wait_no_ack", {31'd0, swap_ack}, 0);
    frame_start = 1'b1;
    step();
    chk("sw3_ack", {31'd0, swap_ack}, 1);
    chk("sw3_front", {31'd0, front_sel}, 1);
    step();
    frame_start = 1'b1;
    step();
    chk("dup_no_ack", {31'd0, swap_ack}, 0);
    chk("dup_front", {31'd0, front_sel}, 1);
    do_rd(adr(4, 2), 3'd0);
    do_rd(adr(7, 3), 3'd0);
    do_rd(adr(0, 0), 3'd0);

    do_wr(adr(2, 26), 3'd3);
    do_wr(adr(1, 23), 3'd4);
    do_wr(adr(9, 31), 3'd6);
    swap_req = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    chk("sw4_front", {31'd0, front_sel}, 0);
    do_rd(adr(2, 26), 3'd0);
    do_rd(adr(9, 31), 3'd0);
    do_rd(adr(1, 23), 3'd4);
    do_rd(adr(0, 0), 3'd7);

    swap_req = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    chk("sw5_front", {31'd0, front_sel}, 1);
    do_wr(adr(20, 5), 3'd6);

    clear_req = 1'b1;
    step();
    repeat (500) step();
    reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, busy}, 1);
    chk("mid_front", {31'd0, front_sel}, 0);
    chk("mid_rdata", {29'd0, rdata}, 0);
    chk("mid_ack", {31'd0, swap_ack}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_busy(n);
    chk("reinit_len", n, 1024);
    do_rd(adr(20, 5), 3'd0);
    do_rd(adr(0, 0), 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
